// File: rtl/fetch_decode_pkg.sv
// Shared opcode map, FSM state encoding and strobe bundle for the fetch_decode sequencer.
package fetch_decode_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [3:0] OP_ADD_R = 4'h5;
    localparam logic [3:0] OP_ST_P  = 4'h6;
    localparam logic [3:0] OP_LD_P  = 4'h7;
    localparam logic [3:0] OP_DEC   = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_ST_R  = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hC;
    localparam logic [3:0] OP_LDI   = 4'hD;
    localparam logic [3:0] OP_JMP   = 4'hE;
    localparam logic [3:0] OP_RST   = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic ldi;
        logic st_p;
        logic ld_p;
        logic st_r;
        logic add_r;
        logic dec;
        logic inc;
    } strobe_t;

endpackage

// File: rtl/fetch_decode_op_decoder.sv
// Combinational opcode decode: IR[3:0] -> one-hot execute strobes plus control-flow flags.
module fetch_decode_op_decoder
    import fetch_decode_pkg::*;
(
    input  logic [3:0] i_op,
    output strobe_t    o_strb,
    output logic       o_is_jmp,
    output logic       o_is_rst,
    output logic       o_is_illegal
);

    always_comb begin
        o_strb       = '0;
        o_is_jmp     = 1'b0;
        o_is_rst     = 1'b0;
        o_is_illegal = 1'b0;
        case (i_op)
            OP_ADD_R: o_strb.add_r = 1'b1;
            OP_ST_P:  o_strb.st_p  = 1'b1;
            OP_LD_P:  o_strb.ld_p  = 1'b1;
            OP_DEC:   o_strb.dec   = 1'b1;
            OP_INC:   o_strb.inc   = 1'b1;
            OP_ST_R:  o_strb.st_r  = 1'b1;
            OP_LDI:   o_strb.ldi   = 1'b1;
            OP_NOP:   ;
            OP_JMP:   o_is_jmp     = 1'b1;
            OP_RST:   o_is_rst     = 1'b1;
            default:  o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Two-cycle FETCH/EXEC program sequencer for the PLC datapath.
// Define FETCH_ILLEGAL_TRAP_EN to trap on undefined opcodes; otherwise they run as NOP.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_opcode,
    input  logic [7:0]        rom_operand,
    output logic [7:0]        operand,
    output logic              op_ldi,
    output logic              op_st_p,
    output logic              op_ld_p,
    output logic              op_st_r,
    output logic              op_add_r,
    output logic              op_dec,
    output logic              op_inc,
    output logic              soft_rst,
    output logic [ADDR_W-1:0] pc,
    output logic              illegal
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [3:0]        r_ir;
    logic [7:0]        r_operand;
    strobe_t           w_dec_strb, w_strb;
    logic              w_is_jmp, w_is_rst, w_is_illegal;
    logic              w_exec, w_trap;
    logic              w_unused_opcode_hi;

    // Only the low nibble of the opcode byte carries meaning.
    assign w_unused_opcode_hi = &{1'b0, rom_opcode[7:4]};

    fetch_decode_op_decoder u_op_decoder (
        .i_op         (r_ir),
        .o_strb       (w_dec_strb),
        .o_is_jmp     (w_is_jmp),
        .o_is_rst     (w_is_rst),
        .o_is_illegal (w_is_illegal)
    );

    // Strobe-issuing EXEC cycle; reset and hold both suppress it.
    assign w_exec = (r_state == ST_EXEC) && !hold && !rst;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic r_illegal;

    assign w_trap  = (r_state == ST_EXEC) && w_is_illegal;
    assign illegal = r_illegal;

    always_ff @(posedge clk) begin
        if (rst)
            r_illegal <= 1'b0;
        else if (!hold && w_trap)
            r_illegal <= 1'b1;
    end
`else
    logic w_unused_illegal;

    assign w_unused_illegal = w_is_illegal;
    assign w_trap  = 1'b0;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_FETCH;
        else if (!hold)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_FETCH;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = w_trap ? ST_TRAP : ST_FETCH;
`ifdef FETCH_ILLEGAL_TRAP_EN
            ST_TRAP:  w_state_nxt = ST_TRAP;
`endif
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_strb   = '0;
        soft_rst = 1'b0;
        if (w_exec) begin
            w_strb   = w_dec_strb;
            soft_rst = w_is_rst;
        end
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (r_state == ST_EXEC) begin
            if (w_is_jmp)
                w_pc_nxt = ADDR_W'(r_operand);
            else if (w_is_rst)
                w_pc_nxt = RST_VEC;
            else if (!w_trap)
                w_pc_nxt = r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RST_VEC;
            r_ir      <= OP_NOP;
            r_operand <= '0;
        end else if (!hold) begin
            r_pc <= w_pc_nxt;
            if (r_state == ST_FETCH) begin
                r_ir      <= rom_opcode[3:0];
                r_operand <= rom_operand;
            end
        end
    end

    assign rom_addr = r_pc;
    assign pc       = r_pc;
    assign operand  = r_operand;
    assign op_ldi   = w_strb.ldi;
    assign op_st_p  = w_strb.st_p;
    assign op_ld_p  = w_strb.ld_p;
    assign op_st_r  = w_strb.st_r;
    assign op_add_r = w_strb.add_r;
    assign op_dec   = w_strb.dec;
    assign op_inc   = w_strb.inc;

endmodule

// File: tb/tb_fetch_decode.sv
// Table-driven bench for fetch_decode: bench-side ROM, per-cycle expected outputs.
module tb_fetch_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic [7:0] rom_addr, rom_opcode, rom_operand, operand, pc;
    logic       op_ldi, op_st_p, op_ld_p, op_st_r, op_add_r, op_dec, op_inc;
    logic       soft_rst, illegal;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [256];

    always #5 clk = ~clk;

    assign rom_opcode  = rom[rom_addr][15:8];
    assign rom_operand = rom[rom_addr][7:0];

    fetch_decode dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .rom_addr    (rom_addr),
        .rom_opcode  (rom_opcode),
        .rom_operand (rom_operand),
        .operand     (operand),
        .op_ldi      (op_ldi),
        .op_st_p     (op_st_p),
        .op_ld_p     (op_ld_p),
        .op_st_r     (op_st_r),
        .op_add_r    (op_add_r),
        .op_dec      (op_dec),
        .op_inc      (op_inc),
        .soft_rst    (soft_rst),
        .pc          (pc),
        .illegal     (illegal)
    );

    // Strobe vector order: {ldi, st_p, ld_p, st_r, add_r, dec, inc}
    typedef struct {
        logic       h;
        logic       r;
        logic [7:0] addr;
        logic [6:0] strb;
        logic       srst;
        logic [7:0] opnd;
        logic       ill;
    } vec_t;

    vec_t vq[$];

    localparam logic [6:0] ES [11] = '{7'h00, 7'h40, 7'h20, 7'h01, 7'h02, 7'h10,
                                       7'h08, 7'h04, 7'h00, 7'h00, 7'h00};
    localparam logic [7:0] EO [11] = '{8'h00, 8'h07, 8'h01, 8'h00, 8'h55, 8'h02,
                                       8'h03, 8'h04, 8'h00, 8'h00, 8'h03};

    function automatic logic [6:0] strobes();
        return {op_ldi, op_st_p, op_ld_p, op_st_r, op_add_r, op_dec, op_inc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic h, input logic r, input logic [7:0] addr,
                       input logic [6:0] strb, input logic srst, input logic [7:0] opnd,
                       input logic ill);
        vq.push_back('{h, r, addr, strb, srst, opnd, ill});
    endtask

    task automatic rom_clear();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0C00;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset rom_addr", 32'(rom_addr), 32'h00);
        chk("reset pc", 32'(pc), 32'h00);
        chk("reset strobes", 32'(strobes()), 32'h00);
        chk("reset soft_rst", 32'(soft_rst), 32'h0);
        chk("reset operand", 32'(operand), 32'h00);
        chk("reset illegal", 32'(illegal), 32'h0);
        rst = 1'b0;
    endtask

    // Each record covers one clock period; outputs sampled at the falling edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            hold = vq[i].h;
            rst  = vq[i].r;
            @(negedge clk);
            chk($sformatf("%s[%0d] rom_addr", tag, i), 32'(rom_addr), 32'(vq[i].addr));
            chk($sformatf("%s[%0d] pc", tag, i), 32'(pc), 32'(vq[i].addr));
            chk($sformatf("%s[%0d] strobes", tag, i), 32'(strobes()), 32'(vq[i].strb));
            chk($sformatf("%s[%0d] soft_rst", tag, i), 32'(soft_rst), 32'(vq[i].srst));
            chk($sformatf("%s[%0d] illegal", tag, i), 32'(illegal), 32'(vq[i].ill));
            if (vq[i].strb != 7'h00)
                chk($sformatf("%s[%0d] operand", tag, i), 32'(operand), 32'(vq[i].opnd));
            @(posedge clk);
            #1;
        end
        vq.delete();
        rst  = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        // Main program: every data op, opcode upper nibble ignored, JMP back to 3.
        rom_clear();
        rom[0]  = 16'h0C00; rom[1] = 16'h0D07; rom[2] = 16'h0601; rom[3]  = 16'h0900;
        rom[4]  = 16'h3855; rom[5] = 16'h0702; rom[6] = 16'h0B03; rom[7]  = 16'h0504;
        rom[8]  = 16'h0C00; rom[9] = 16'h0C00; rom[10] = 16'h0E03;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            add(0, 0, 8'(k), 7'h00, 0, 8'h00, 0);
            add(0, 0, 8'(k), ES[k], 0, EO[k], 0);
        end
        add(0, 0, 8'h03, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h03, 7'h01, 0, 8'h00, 0);
        run_table("main");

        // PC wrap 255 -> 0, then JMP loops back to 255.
        rom_clear();
        rom[0] = 16'h0EFF;
        do_reset();
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'hFF, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'hFF, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'hFF, 7'h00, 0, 8'h00, 0);
        run_table("wrap");

        // Hold for 3 cycles across EXEC of INC A.
        rom_clear();
        rom[0] = 16'h0911;
        do_reset();
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(1, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(1, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(1, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h01, 0, 8'h11, 0);
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h02, 7'h00, 0, 8'h00, 0);
        run_table("hold");

        // RST instruction at 14 reached via JMP.
        rom_clear();
        rom[0]  = 16'h0E0E;
        rom[14] = 16'h0F77;
        do_reset();
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h0E, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h0E, 7'h00, 1, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h0E, 7'h00, 0, 8'h00, 0);
        run_table("softrst");

        // External rst during EXEC of ADD R suppresses the strobe.
        rom_clear();
        rom[1] = 16'h0504;
        do_reset();
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 1, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        run_table("midrst");

        // Undefined opcode 0x0A.
        rom_clear();
        rom[0] = 16'h0A00;
        do_reset();
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
`ifdef FETCH_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) add(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
`else
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h01, 7'h00, 0, 8'h00, 0);
        add(0, 0, 8'h02, 7'h00, 0, 8'h00, 0);
`endif
        run_table("illegal");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
